// File: rtl/demux1x4_reg.sv
// Registered 1:4 demux with valid/ready handshake.
// Four single-entry lanes, each drained by its own ready, with delivery counters.
module demux1x4_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   i,
  input  logic [1:0]         sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_st_t;

  lane_st_t         st     [4];
  lane_st_t         st_nxt [4];
  logic [WIDTH-1:0] dat    [4];
  logic [CNT_W-1:0] tally  [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  // Handshake decode and per-lane next state.
  // Only the addressed lane gates in_ready, so other full lanes never stall the source.
  always_comb begin
    in_ready = (st[sel] == EMPTY) || out_ready[sel];
    accept   = in_valid && in_ready;
    load     = '0;
    drain    = '0;
    for (int n = 0; n < 4; n++) begin
      st_nxt[n] = st[n];
      load[n]   = accept && (sel == 2'(n));
      drain[n]  = (st[n] == FULL) && out_ready[n];
      if (load[n]) begin
        st_nxt[n] = FULL;
      end else if (drain[n]) begin
        st_nxt[n] = EMPTY;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        st[n] <= EMPTY;
      end else begin
        st[n] <= st_nxt[n];
      end
    end
  end

  // Lane data: loaded on accept, otherwise held even after delivery.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        dat[n] <= '0;
      end else if (load[n]) begin
        dat[n] <= i;
      end
    end
  end

  // Delivery counters, wrapping silently.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (rst) begin
        tally[n] <= '0;
      end else if (drain[n]) begin
        tally[n] <= tally[n] + CNT_W'(1);
      end
    end
  end

  // Flatten lane state onto the output buses.
  always_comb begin
    out       = '0;
    out_valid = '0;
    cnt       = '0;
    for (int n = 0; n < 4; n++) begin
      out[n*WIDTH +: WIDTH] = dat[n];
      out_valid[n]          = (st[n] == FULL);
      cnt[n*CNT_W +: CNT_W] = tally[n];
    end
  end

endmodule

// File: tb/tb_demux1x4_reg.sv
// Directed bench for demux1x4_reg.
// Two instances share stimulus: 8-bit counters and 2-bit wrapping counters.
module tb_demux1x4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i;
  logic [1:0]  sel;
  logic        in_valid;
  logic [3:0]  out_ready;

  logic        rdy0;
  logic        rdy1;
  logic [15:0] out0;
  logic [15:0] out1;
  logic [3:0]  ov0;
  logic [3:0]  ov1;
  logic [31:0] cnt0;
  logic [7:0]  cnt1;

  int total = 0;
  int bad   = 0;

  logic [3:0] q [4][$];
  logic [3:0] full;
  int         ecnt [4];

  always #5 clk = ~clk;

  demux1x4_reg #(.WIDTH(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .i(i), .sel(sel),
    .in_valid(in_valid), .in_ready(rdy0),
    .out(out0), .out_valid(ov0),
    .out_ready(out_ready), .cnt(cnt0)
  );

  demux1x4_reg #(.WIDTH(4), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .i(i), .sel(sel),
    .in_valid(in_valid), .in_ready(rdy1),
    .out(out1), .out_valid(ov1),
    .out_ready(out_ready), .cnt(cnt1)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check handshake, score deliveries, update model, advance.
  task automatic cyc();
    logic er;
    logic [3:0] d;
    #1;
    er = !full[sel] || out_ready[sel];
    chk("in_ready0", {31'b0, rdy0}, {31'b0, er});
    chk("in_ready1", {31'b0, rdy1}, {31'b0, er});
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        ecnt[n] = 0;
      end
      full = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (full[n] && out_ready[n]) begin
          if (q[n].size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            d = q[n].pop_front();
            chk("deliver0", {28'b0, out0[n*4 +: 4]}, {28'b0, d});
            chk("deliver1", {28'b0, out1[n*4 +: 4]}, {28'b0, d});
          end
          ecnt[n]++;
          full[n] = 1'b0;
        end
      end
      if (in_valid && er) begin
        q[sel].push_back(i);
        full[sel] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid0", {28'b0, ov0}, {28'b0, full});
    chk("out_valid1", {28'b0, ov1}, {28'b0, full});
    for (int n = 0; n < 4; n++) begin
      chk("cnt0", {24'b0, cnt0[n*8 +: 8]}, {24'b0, 8'(ecnt[n])});
      chk("cnt1", {30'b0, cnt1[n*2 +: 2]}, {30'b0, 2'(ecnt[n])});
    end
  endtask

  initial begin
    logic [1:0] wrap [5];
    wrap[0] = 2'd1;
    wrap[1] = 2'd2;
    wrap[2] = 2'd3;
    wrap[3] = 2'd0;
    wrap[4] = 2'd1;
    full      = '0;
    for (int n = 0; n < 4; n++) ecnt[n] = 0;
    rst       = 1'b1;
    i         = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out", {16'b0, out0}, 32'd0);
    chk("rst_cnt", cnt0, 32'd0);

    // basic steer to lane 2
    i = 4'hA; sel = 2'd2; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("steer_ov", {28'b0, ov0}, 32'b0100);
    chk("steer_l2", {28'b0, out0[11:8]}, 32'hA);
    chk("steer_oth", {16'b0, out0 & 16'hF0FF}, 32'd0);
    out_ready = 4'b0100;
    cyc();
    chk("steer_drn", {28'b0, ov0}, 32'd0);
    chk("steer_cnt", {24'b0, cnt0[23:16]}, 32'd1);
    chk("steer_hold", {28'b0, out0[11:8]}, 32'hA);

    // backpressure isolation on lane 1
    out_ready = 4'b0000;
    i = 4'h5; sel = 2'd1; in_valid = 1'b1;
    cyc();
    i = 4'h7;
    #1;
    chk("bp_rdy", {31'b0, rdy0}, 32'd0);
    cyc();
    chk("bp_l1", {28'b0, out0[7:4]}, 32'h5);
    i = 4'h9; sel = 2'd3;
    #1;
    chk("iso_rdy", {31'b0, rdy0}, 32'd1);
    cyc();
    chk("iso_l3", {28'b0, out0[15:12]}, 32'h9);
    chk("iso_l1", {28'b0, out0[7:4]}, 32'h5);

    // fill lanes 0 and 2, then drain all four at once
    i = 4'h3; sel = 2'd0;
    cyc();
    i = 4'hC; sel = 2'd2;
    cyc();
    in_valid = 1'b0;
    chk("all_full", {28'b0, ov0}, 32'b1111);
    out_ready = 4'b1111;
    cyc();
    chk("all_drn", {28'b0, ov0}, 32'd0);
    chk("all_cnt", cnt0, 32'h01_02_01_01);

    // full throughput on lane 0
    out_ready = 4'b0001;
    sel = 2'd0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i = 4'(k);
      cyc();
      chk("tp_l0", {28'b0, out0[3:0]}, k);
    end
    in_valid = 1'b0;
    cyc();
    chk("tp_cnt", {24'b0, cnt0[7:0]}, 32'd5);

    // reset mid-traffic with lane 2 full and a concurrent handshake
    out_ready = 4'b0000;
    i = 4'hE; sel = 2'd2; in_valid = 1'b1;
    cyc();
    out_ready = 4'b0100;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    chk("mid_ov", {28'b0, ov0}, 32'd0);
    chk("mid_out", {16'b0, out0}, 32'd0);
    chk("mid_cnt", cnt0, 32'd0);
    chk("mid_cnt1", {24'b0, cnt1}, 32'd0);
    #1;
    chk("mid_rdy", {31'b0, rdy0}, 32'd1);

    // counter wrap on lane 3 with 2-bit counters
    out_ready = 4'b1000;
    sel = 2'd3; in_valid = 1'b1;
    i = 4'h1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      i = 4'(k + 2);
      if (k == 4) in_valid = 1'b0;
      cyc();
      chk("wrap", {30'b0, cnt1[7:6]}, {30'b0, wrap[k]});
    end
    chk("wrap_c0", {24'b0, cnt0[31:24]}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1x4_reg.md
Name: demux1x4_reg

Overview:
- Registered 1-to-4 demultiplexer with a valid/ready handshake. It is the distribution-side counterpart of the team's 4:1 data mux.
- Each input word is steered by a 2-bit select into one of four single-entry output holding registers. Each output drains independently under its own ready signal.
- Per-output transfer counters are provided for bring-up and debug.
- Sits between a shared source (bus, serial front end) and four consumers.

Parameters:
- WIDTH, 1: data width of input word and of each output lane.
- CNT_W, 8: width of each per-output transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- i  input  WIDTH  input data word.
- sel  input  2  destination lane (0..3) for the word on i.
- in_valid  input  1  i/sel valid this cycle.
- in_ready  output  1  block can accept i this cycle (combinational).
- out  output  4*WIDTH  lane n occupies bits [n*WIDTH +: WIDTH]; registered.
- out_valid  output  4  lane n holds valid data.
- out_ready  input  4  consumer n accepts lane n this cycle.
- cnt  output  4*CNT_W  lane n count of words delivered (out_valid[n] & out_ready[n]), slice [n*CNT_W +: CNT_W].

Behaviour:
- Reset: on a clk edge with rst=1, out=0, out_valid=0000 and cnt=0. rst overrides any concurrent handshake. Reset mid-transfer discards held words; no delivery is counted.
- in_ready = ~out_valid[sel] | out_ready[sel]. It depends only on the addressed lane, so other full lanes do not block.
- Accept: an input word is accepted when in_valid & in_ready. On that edge, lane sel loads i and sets out_valid[sel]=1. Latency is 1 cycle, so data is visible on out the cycle after acceptance.
- Drain: when out_valid[n] & out_ready[n], lane n is delivered. If the same edge is not also loading lane n, out_valid[n] clears. Lane data is held, not zeroed, after delivery.
- Simultaneous accept and drain on the same lane: old word is delivered and counted, new word is loaded, and out_valid stays 1. This supports full throughput of one word per cycle into a lane.
- Lanes are independent: any number of lanes may drain on the same edge. At most one lane loads per cycle.
- Stall: in_valid=1 with in_ready=0 means no state change for lane sel. The source must hold i/sel stable until accepted. The block does not check this.
- out_valid[n]=0: out lane n value is don't-care for consumers, but the block must not modify it.
- Counters: cnt[n] increments by 1 per delivery on lane n and wraps from 2^CNT_W-1 to 0 with no flag.
- in_valid=0: sel and i are ignored, and in_ready still reflects the current sel.
- Lane state machine (per lane): EMPTY→FULL on load. FULL→EMPTY on drain without load. FULL→FULL on drain+load. FULL→FULL on hold. EMPTY→EMPTY otherwise.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic with lane 2 full → next cycle out_valid=0000, cnt all 0, out=0, in_ready=1.
- Basic steer, WIDTH=4: i=4'hA, sel=2, in_valid=1, out_ready=0000 → next cycle out_valid=0100, lane2=A, other lanes 0. Then out_ready[2]=1 → out_valid=0000, cnt[2]=1.
- Backpressure isolation: lane 1 full with out_ready[1]=0. Then sel=1 → in_ready=0 and lane1 keeps old value. Then sel=3 → in_ready=1, lane 3 loads, lane 1 is unchanged.
- Full throughput: sel=0 every cycle, i=1,2,3,4, out_ready[0]=1 → in_ready stays 1. Lane 0 shows 1,2,3,4 on consecutive cycles, and cnt[0]=4 one cycle after the last word.
- Concurrent drain: lanes 0–3 full, all out_ready=1 on one cycle → out_valid=0000 and each cnt increments by 1.
- Counter wrap: CNT_W=2, five deliveries on lane 3 → cnt[3] sequence 1,2,3,0,1.
